// File: rtl/mod_counter_n.sv
// rtl/mod_counter_n.sv - run-controlled modulo-(limit+1) up/down counter with wrap or one-shot mode
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   rst    - synchronous, active-high reset
//   ena    - advance qualifier; the count moves only in cycles with ena=1
//   start  - begin or restart a run; samples limit, mode and dir
//   abort  - end the current run without completion (count forced to 0)
//   mode   - 0 = wrap (continuous), 1 = one-shot
//   dir    - 0 = count up (0 -> limit), 1 = count down (limit -> 0)
//   limit  - terminal value; a run spans limit+1 states
//   count  - current count (registered)
//   busy   - high while a run is active (registered)
//   done   - one-cycle pulse following each terminal event (registered)
//
// Priority of controls: rst > abort > start > ena.

module mod_counter_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;

    // Run configuration captured at start; the live inputs are ignored
    // until the next start so a run always completes with the shape it began with.
    logic [WIDTH-1:0] lim_q;
    logic             mode_q;
    logic             dir_q;

    logic [WIDTH-1:0] load_val;   // start value for a run beginning this cycle
    logic [WIDTH-1:0] reload_val; // start value of the current (latched) run
    logic [WIDTH-1:0] step_val;   // count moved one step toward the terminal
    logic             at_term;    // count sits on the terminal value of the current run

    always_comb begin
        load_val   = dir ? limit : '0;
        reload_val = dir_q ? lim_q : '0;
        // Modulo 2^WIDTH arithmetic; it never actually wraps because the
        // terminal check stops the step before passing 0 or lim_q.
        step_val   = dir_q ? (count - WIDTH'(1)) : (count + WIDTH'(1));
        at_term    = dir_q ? (count == '0) : (count == lim_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            lim_q  <= '0;
            mode_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only a terminal event below re-arms it.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort outranks start, so a simultaneous abort keeps us idle.
                    if (start && !abort) begin
                        lim_q  <= limit;
                        mode_q <= mode;
                        dir_q  <= dir;
                        count  <= load_val;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        count <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (start) begin
                        // Restart regardless of ena; a restart is not a completion.
                        lim_q  <= limit;
                        mode_q <= mode;
                        dir_q  <= dir;
                        count  <= load_val;
                    end else if (ena) begin
                        if (at_term) begin
                            done <= 1'b1;
                            if (mode_q) begin
                                // One-shot: hold the terminal value and fall idle.
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end else begin
                                count <= reload_val;
                            end
                        end else begin
                            count <= step_val;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mod_counter_n.md
MOD_COUNTER_N -- requirements
Module: mod_counter_n

Interface
REQ-001 Parameter: WIDTH, default 4, counter and limit width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: ena  input  1  advance qualifier (tick); count moves only in cycles with ena=1.
REQ-005 Port: start  input  1  begin or restart a run; samples limit, mode and dir.
REQ-006 Port: abort  input  1  terminate the current run without completion.
REQ-007 Port: mode  input  1  0 = wrap (continuous), 1 = one-shot.
REQ-008 Port: dir  input  1  0 = count up, 1 = count down.
REQ-009 Port: limit  input  WIDTH  terminal value; the run spans limit+1 states.
REQ-010 Port: count  output  WIDTH  current count; registered.
REQ-011 Port: busy  output  1  high while in RUN; registered.
REQ-012 Port: done  output  1  one-cycle terminal pulse; registered.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-014 Start value: 0 when dir=0; limit when dir=1. Terminal value: limit when dir=0; 0 when dir=1.
REQ-015 IDLE with start=1 SHALL do all of the following at that edge:
- latch limit, mode and dir into internal registers;
- load count with the start value;
- enter RUN and set busy=1.
REQ-016 IDLE with start=0 SHALL hold count and busy=0; ena SHALL have no effect.
REQ-017 RUN, ena=1, count not at terminal: count SHALL step by one toward the terminal (+1 up, -1 down).
REQ-018 RUN, ena=1, count at terminal, latched mode=0: count SHALL reload the start value, the FSM SHALL stay in RUN, and done=1 for the next cycle only.
REQ-019 RUN, ena=1, count at terminal, latched mode=1: count SHALL hold the terminal value, the FSM SHALL enter IDLE (busy=0), and done=1 for the next cycle only.
REQ-020 RUN, ena=0: count, state and latched configuration SHALL hold.
REQ-021 done SHALL be 0 in every cycle not covered by REQ-018/REQ-019; it SHALL never be high for two consecutive cycles unless limit=0 and ena=1 in consecutive cycles.
REQ-022 Changes on limit, mode or dir during RUN SHALL be ignored until the next start.
REQ-023 start=1 during RUN SHALL restart the run per REQ-015, regardless of ena; no done is generated.
REQ-024 abort=1 during RUN SHALL force count=0 and IDLE; no done is generated. abort in IDLE has no effect.
REQ-025 Priority: rst > abort > start > ena.
REQ-026 latched limit=0: every ena in RUN is a terminal event; done is asserted after each one.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH internally; count SHALL never exceed the latched limit.

Reset
REQ-028 At any clock edge with rst=1 the block SHALL set the following, overriding all other inputs including mid-run operation:
- count=0, busy=0, done=0;
- FSM=IDLE;
- latched limit=0, latched mode=0, latched dir=0.
REQ-029 In the first cycle after rst deasserts, the block SHALL accept start.

Verification
REQ-030 WIDTH=4, limit=7, mode=0, dir=0, start then ena held high -> count 0,1,…,7,0,…; done high exactly one cycle after each 7->0 transition (every 8 ena); busy stays 1.
REQ-031 limit=5, mode=1, dir=1, start, ena high -> count 5,4,3,2,1,0; the ena at 0 gives done=1 for one cycle, busy=0, count holds 0; further ena has no effect.
REQ-032 limit=3, wrap, up, ena alternating 1/0 -> count advances only on ena=1 cycles; done follows the 4th ena.
REQ-033 Up run, limit=9: abort at count=3 -> count=0, busy=0, no done. Repeat with start and abort asserted together -> abort wins.
REQ-034 Run with limit=6; change limit to 2 mid-run -> wrap still at 6. Restart with limit=0, one-shot -> done after the first ena, busy=0.
REQ-035 rst=1 while count=4 with start=1 -> next cycle count=0, busy=0, done=0, FSM=IDLE.
